// File: rtl/dmux8way_scheduler.sv
// Round-robin scheduler steering one word stream onto 8 enabled lanes via a one-entry buffer.
// Latency: a word accepted at edge N is presented on out_valid/out_data from edge N, departs at N+1 earliest.
// Backpressure: in_ready falls while the buffered word's lane stalls, or when no lane is enabled.
module dmux8way_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       lane_en,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       sel,
    output logic             busy,
    output logic [15:0]      xfer_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       valid_q, valid_d;
    logic [15:0]      cnt_q, cnt_d;

    logic       dep;
    logic       load;
    logic [2:0] base;
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;

    assign busy     = (state_q == FULL);
    assign dep      = busy & out_ready[sel_q];
    assign in_ready = (~busy | dep) & (|lane_en);
    assign load     = in_valid & in_ready;

    // Search base follows the pointer as it will be after a same-cycle departure.
    always_comb begin
        base  = dep ? sel_q + 3'd1 : ptr_q;
        pick  = base;
        found = 1'b0;
        idx   = base;
        for (int k = 0; k < 8; k++) begin
            idx = base + k[2:0];
            if (!found && lane_en[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (dep) begin
            ptr_d   = sel_q + 3'd1;
            cnt_d   = cnt_q + 16'd1;
            state_d = EMPTY;
            valid_d = 8'h00;
        end
        if (load) begin
            data_d  = in_data;
            sel_d   = pick;
            state_d = FULL;
            valid_d = 8'h01 << pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            valid_q <= 8'h00;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign sel        = sel_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_dmux8way_scheduler.sv
// Directed vector bench for dmux8way_scheduler: table of per-cycle stimulus and expected state,
// plus hand-written sequences for counter wrap and asynchronous reset while busy.
module tb_dmux8way_scheduler;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  lane_en;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] out_data;
    logic [2:0]  sel;
    logic        busy;
    logic [15:0] xfer_count;

    int n_chk;
    int n_fail;

    dmux8way_scheduler #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .lane_en    (lane_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sel        (sel),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic [7:0]  rdy;
        logic        iv;
        logic [15:0] din;
        logic        exp_ir;
        logic        exp_busy;
        logic [2:0]  exp_sel;
        logic [7:0]  exp_ov;
        logic [15:0] exp_dat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] en, input logic [7:0] rdy, input logic iv,
                       input logic [15:0] din, input logic ir, input logic bsy,
                       input logic [2:0] s, input logic [15:0] dat, input logic [15:0] cnt);
        vec_t v;
        v.en       = en;
        v.rdy      = rdy;
        v.iv       = iv;
        v.din      = din;
        v.exp_ir   = ir;
        v.exp_busy = bsy;
        v.exp_sel  = s;
        v.exp_ov   = bsy ? (8'h01 << s) : 8'h00;
        v.exp_dat  = dat;
        v.exp_cnt  = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        lane_en   = 8'hFF;
        out_ready = 8'hFF;

        // Stream of ten words across all lanes, then drain.
        for (int k = 1; k <= 10; k++)
            add(8'hFF, 8'hFF, 1'b1, 16'(k), 1'b1, 1'b1, 3'((k - 1) % 8), 16'(k), 16'(k - 1));
        add(8'hFF, 8'hFF, 1'b0, 16'h0, 1'b1, 1'b0, 3'd1, 16'd10, 16'd10);
        // Sparse mask 2,5,7 with pointer wrap.
        add(8'hA4, 8'hFF, 1'b1, 16'h0020, 1'b1, 1'b1, 3'd2, 16'h0020, 16'd10);
        add(8'hA4, 8'hFF, 1'b1, 16'h0021, 1'b1, 1'b1, 3'd5, 16'h0021, 16'd11);
        add(8'hA4, 8'hFF, 1'b1, 16'h0022, 1'b1, 1'b1, 3'd7, 16'h0022, 16'd12);
        add(8'hA4, 8'hFF, 1'b1, 16'h0023, 1'b1, 1'b1, 3'd2, 16'h0023, 16'd13);
        add(8'hA4, 8'hFF, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0023, 16'd14);
        // Stall on lane 0 for five cycles.
        add(8'h01, 8'h00, 1'b1, 16'hBEEF, 1'b1, 1'b1, 3'd0, 16'hBEEF, 16'd14);
        for (int k = 0; k < 5; k++)
            add(8'h01, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b1, 3'd0, 16'hBEEF, 16'd14);
        add(8'h01, 8'h01, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'hBEEF, 16'd15);
        add(8'h01, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'hBEEF, 16'd15);
        // Lane 3 committed, then disabled while stalled.
        add(8'h08, 8'h00, 1'b1, 16'h3333, 1'b1, 1'b1, 3'd3, 16'h3333, 16'd15);
        add(8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h3333, 16'd15);
        add(8'h00, 8'h00, 1'b1, 16'h9999, 1'b0, 1'b1, 3'd3, 16'h3333, 16'd15);
        add(8'h81, 8'h08, 1'b1, 16'h4444, 1'b1, 1'b1, 3'd7, 16'h4444, 16'd16);
        add(8'hFF, 8'hFF, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd7, 16'h4444, 16'd17);
        // No lanes enabled, then lane 4 only; buffered word drains with mask cleared.
        for (int k = 0; k < 3; k++)
            add(8'h00, 8'hFF, 1'b1, 16'h5555, 1'b0, 1'b0, 3'd7, 16'h4444, 16'd17);
        add(8'h10, 8'h00, 1'b1, 16'h5555, 1'b1, 1'b1, 3'd4, 16'h5555, 16'd17);
        add(8'h00, 8'hFF, 1'b1, 16'h6666, 1'b0, 1'b0, 3'd4, 16'h5555, 16'd18);

        #12;
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_sel", 16'(sel), 16'h0);
        check("rst_count", xfer_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            lane_en   = vecs[i].en;
            out_ready = vecs[i].rdy;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            #1;
            check($sformatf("v%0d_in_ready", i), 16'(in_ready), 16'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy", i), 16'(busy), 16'(vecs[i].exp_busy));
            check($sformatf("v%0d_sel", i), 16'(sel), 16'(vecs[i].exp_sel));
            check($sformatf("v%0d_out_valid", i), 16'(out_valid), 16'(vecs[i].exp_ov));
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_dat);
            check($sformatf("v%0d_count", i), xfer_count, vecs[i].exp_cnt);
        end

        // Long stream: first edge loads only, each later edge departs one word.
        @(negedge clk);
        lane_en   = 8'hFF;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int k = 0; k < 65518; k++) begin
            in_data = 16'(k);
            @(negedge clk);
        end
        check("near_wrap_count", xfer_count, 16'hFFFF);
        check("near_wrap_busy", 16'(busy), 16'h1);
        @(negedge clk);
        check("wrap_count", xfer_count, 16'h0000);
        check("wrap_busy", 16'(busy), 16'h1);

        // Asynchronous reset while a word is buffered.
        out_ready = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 16'(out_valid), 16'h0);
        check("arst_busy", 16'(busy), 16'h0);
        check("arst_count", xfer_count, 16'h0);
        check("arst_sel", 16'(sel), 16'h0);
        check("arst_out_data", out_data, 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("arst_hold_count", xfer_count, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmux8way_scheduler.md
Name: dmux8way_scheduler

Overview:
Stream controller for the 8-way demultiplexer. Accepts a single valid/ready word stream and distributes words round-robin across 8 output lanes, skipping lanes disabled in a live enable mask. It owns the 3-bit select that steers the shared datapath, and it holds each word in a one-entry output buffer until the selected lane accepts it. It also counts completed transfers.

Parameters:
WIDTH, 16, data word width (Hack word).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word present.
in_ready  output  1  scheduler can accept a word this cycle.
in_data  input  WIDTH  upstream word.
lane_en  input  8  per-lane enable mask; bit i enables lane i.
out_valid  output  8  one-hot valid; only bit sel can be set.
out_ready  input  8  per-lane ready from downstream.
out_data  output  WIDTH  buffered word, shared by all lanes.
sel  output  3  lane committed for the buffered word.
busy  output  1  buffer holds a word.
xfer_count  output  16  completed output transfers, modulo 2^16.

Behaviour:
- Reset values (asynchronous assert, synchronous release): buffer empty, busy=0, out_valid=8'h00, out_data=0, sel=0, internal pointer ptr=0, xfer_count=0.
- State: EMPTY (busy=0) or FULL (busy=1). No other states.
- Departure: dep = busy & out_ready[sel].
- Input ready: in_ready = (~busy | dep) & (|lane_en). This path is combinational from out_ready and lane_en.
- Load: when in_valid & in_ready at an edge:
  - out_data <= in_data; busy <= 1.
  - sel <= first lane i with lane_en[i]=1, searching ptr, ptr+1, ... ptr+7 mod 8.
  - Base for the search: if dep occurs in the same cycle, the search starts at sel+1 mod 8 (the updated ptr value); otherwise it starts at ptr.
- Output: out_valid = busy ? onehot(sel) : 0.
- Departure at an edge:
  - ptr <= sel+1 mod 8 (3-bit wrap, so 7 goes to 0).
  - xfer_count <= xfer_count+1 (16-bit wrap, so FFFF goes to 0000).
  - busy <= 0, unless a load occurs in the same cycle.
- Simultaneous dep and load: both happen in the same edge. Throughput is 1 word/cycle when all enabled lanes are ready.
- Latency: a word accepted at edge N drives out_valid/out_data from edge N, so the earliest departure is edge N+1.
- Stability:
  - While busy, sel and out_data are frozen until dep.
  - Changes to lane_en do not move a committed word, even if its lane is disabled afterwards; that lane must still drain it.
- After a departure with no load: out_data and sel retain their last values. out_valid=0.
- lane_en=0: in_ready=0 and no word is accepted. A word already buffered still departs normally.
- Reset asserted mid-operation: the buffered word is dropped, all state returns to reset values immediately, and no transfer is counted.

Test Plan:
1. Reset, then lane_en=FF, out_ready=FF, in_valid held 1 with data 1,2,...,10 → words land on lanes 0,1,...,7,0,1 (one per cycle); xfer_count=10 after the last departure.
2. lane_en=8'b1010_0100, out_ready=FF, 4 words → lanes 2,5,7,2; ptr wraps 7→0 and the search finds 2.
3. Word 16'hBEEF to lane 0 with out_ready=0 for 5 cycles → out_valid=01 and out_data=BEEF stable; in_ready=0; after out_ready[0]=1, exactly one departure and xfer_count+1.
4. Lane 3 committed, then lane_en[3] cleared while stalled → sel stays 3 and the word departs on lane 3; the next word goes to the next enabled lane after 3.
5. lane_en=00 with in_valid=1 → in_ready=0 and busy=0 indefinitely. Setting lane_en=10 → the next word goes to lane 4.
6. Preload xfer_count near FFFF via a long run, then one more transfer → the count wraps to 0000. Assert rst_n=0 while busy → out_valid=00, busy=0, count=0 with no clock edge required.
